// File: rtl/exc_pipe_collector_pkg.sv
// exc_pipe_collector_pkg: shared exception codes, access sizes and FSM states
package exc_pipe_collector_pkg;

    localparam int EXC_ADEL = 4;
    localparam int EXC_ADES = 5;
    localparam int EXC_OV   = 12;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic {
        IDLE   = 1'b0,
        REPORT = 1'b1
    } state_t;

endpackage

// File: rtl/exc_pipe_collector_exc_prio_enc.sv
// exc_prio_enc: merges upstream, local and address-error exceptions by fixed priority
module exc_prio_enc
    import exc_pipe_collector_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int CODE_W  = 5,
    parameter int ADDR_W  = 32
) (
    input  logic                      in_valid,
    input  logic                      pre_exc_get,
    input  logic [CODE_W-1:0]         pre_exc_code,
    input  logic [NUM_SRC-1:0]        src_get,
    input  logic [NUM_SRC*CODE_W-1:0] src_code,
    input  logic                      mem_is_load,
    input  logic                      mem_is_store,
    input  logic [1:0]                mem_size,
    input  logic [ADDR_W-1:0]         mem_addr,
    input  logic                      addr_ovf,
    output logic                      exc_get,
    output logic [CODE_W-1:0]         exc_code,
    output logic [ADDR_W-1:0]         badvaddr
);

    logic mis;
    logic ae;

    // Lowest-priority cause is applied first so higher-priority causes overwrite it;
    // the reserved size 3 falls into the word check through mem_size[1].
    always_comb begin
        mis      = (mem_size == SZ_HALF && mem_addr[0]) || (mem_size[1] && mem_addr[1:0] != 2'b00);
        ae       = (mem_is_load || mem_is_store) && (mis || addr_ovf);
        exc_get  = 1'b0;
        exc_code = '0;
        badvaddr = '0;
        if (ae) begin
            exc_get  = 1'b1;
            exc_code = mem_is_store ? CODE_W'(EXC_ADES) : CODE_W'(EXC_ADEL);
            badvaddr = mem_addr;
        end
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_get[i]) begin
                exc_get  = 1'b1;
                exc_code = src_code[i*CODE_W +: CODE_W];
                badvaddr = '0;
            end
        end
        if (pre_exc_get) begin
            exc_get  = 1'b1;
            exc_code = pre_exc_code;
            badvaddr = '0;
        end
        if (!in_valid) begin
            exc_get  = 1'b0;
            exc_code = '0;
            badvaddr = '0;
        end
    end

endmodule

// File: rtl/exc_pipe_collector.sv
// exc_pipe_collector: exception-merging pipeline stage that reports to CP0 via req/ack
module exc_pipe_collector
    import exc_pipe_collector_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int CODE_W  = 5,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [ADDR_W-1:0]         in_pc,
    input  logic                      in_bd,
    input  logic                      pre_exc_get,
    input  logic [CODE_W-1:0]         pre_exc_code,
    input  logic [NUM_SRC-1:0]        src_get,
    input  logic [NUM_SRC*CODE_W-1:0] src_code,
    input  logic                      mem_is_load,
    input  logic                      mem_is_store,
    input  logic [1:0]                mem_size,
    input  logic [ADDR_W-1:0]         mem_addr,
    input  logic                      addr_ovf,
    output logic                      out_valid,
    output logic                      out_exc_get,
    output logic [CODE_W-1:0]         out_exc_code,
    output logic [ADDR_W-1:0]         out_pc,
    output logic                      out_bd,
    output logic [ADDR_W-1:0]         out_badvaddr,
    output logic                      exc_req,
    input  logic                      exc_ack,
    output logic                      hold_req,
    output logic [CNT_W-1:0]          exc_count
);

    logic              m_get;
    logic [CODE_W-1:0] m_code;
    logic [ADDR_W-1:0] m_badv;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic              get_q, get_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              bd_q, bd_d;
    logic [ADDR_W-1:0] badv_q, badv_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pending;

    exc_prio_enc #(.NUM_SRC(NUM_SRC), .CODE_W(CODE_W), .ADDR_W(ADDR_W)) u_enc (
        .in_valid    (in_valid),
        .pre_exc_get (pre_exc_get),
        .pre_exc_code(pre_exc_code),
        .src_get     (src_get),
        .src_code    (src_code),
        .mem_is_load (mem_is_load),
        .mem_is_store(mem_is_store),
        .mem_size    (mem_size),
        .mem_addr    (mem_addr),
        .addr_ovf    (addr_ovf),
        .exc_get     (m_get),
        .exc_code    (m_code),
        .badvaddr    (m_badv)
    );

    // Next-state logic: an excepting slot stays in place until CP0 consumes it,
    // and the ack edge replaces it with a bubble and bumps the saturating counter.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        get_d   = get_q;
        code_d  = code_q;
        pc_d    = pc_q;
        bd_d    = bd_q;
        badv_d  = badv_q;
        cnt_d   = cnt_q;
        pending = valid_q && get_q;
        if (state_q == REPORT) begin
            if (exc_ack) begin
                state_d = IDLE;
                valid_d = 1'b0;
                get_d   = 1'b0;
                code_d  = '0;
                pc_d    = '0;
                bd_d    = 1'b0;
                badv_d  = '0;
                cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            end
        end else if (pending) begin
            state_d = REPORT;
        end else if (flush) begin
            valid_d = 1'b0;
            get_d   = 1'b0;
            code_d  = '0;
            pc_d    = '0;
            bd_d    = 1'b0;
            badv_d  = '0;
        end else if (!stall) begin
            valid_d = in_valid;
            get_d   = m_get;
            code_d  = m_code;
            pc_d    = in_pc;
            bd_d    = in_bd;
            badv_d  = m_badv;
        end
    end

    // State register with synchronous reset; reset drops any report in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            get_q   <= 1'b0;
            code_q  <= '0;
            pc_q    <= '0;
            bd_q    <= 1'b0;
            badv_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            get_q   <= get_d;
            code_q  <= code_d;
            pc_q    <= pc_d;
            bd_q    <= bd_d;
            badv_q  <= badv_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_exc_get  = get_q;
    assign out_exc_code = code_q;
    assign out_pc       = pc_q;
    assign out_bd       = bd_q;
    assign out_badvaddr = badv_q;
    assign exc_req      = (state_q == REPORT);
    assign hold_req     = (state_q == REPORT);
    assign exc_count    = cnt_q;

endmodule

// File: tb/tb_exc_pipe_collector.sv
// tb_exc_pipe_collector: directed self-checking bench for exc_pipe_collector
module tb_exc_pipe_collector;

    logic        clk = 1'b0;
    logic        reset, stall, flush, in_valid, in_bd, pre_exc_get;
    logic [31:0] in_pc, mem_addr;
    logic [4:0]  pre_exc_code;
    logic [1:0]  src_get, mem_size;
    logic [9:0]  src_code;
    logic        mem_is_load, mem_is_store, addr_ovf, exc_ack;

    logic        out_valid, out_exc_get, out_bd, exc_req, hold_req;
    logic [4:0]  out_exc_code;
    logic [31:0] out_pc, out_badvaddr;
    logic [7:0]  exc_count;

    logic        s_valid, s_get, s_bd, s_req, s_hold;
    logic [4:0]  s_code;
    logic [31:0] s_pc, s_badv;
    logic [1:0]  s_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exc_pipe_collector dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd),
        .pre_exc_get(pre_exc_get), .pre_exc_code(pre_exc_code),
        .src_get(src_get), .src_code(src_code),
        .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
        .mem_size(mem_size), .mem_addr(mem_addr), .addr_ovf(addr_ovf),
        .out_valid(out_valid), .out_exc_get(out_exc_get), .out_exc_code(out_exc_code),
        .out_pc(out_pc), .out_bd(out_bd), .out_badvaddr(out_badvaddr),
        .exc_req(exc_req), .exc_ack(exc_ack), .hold_req(hold_req), .exc_count(exc_count)
    );

    exc_pipe_collector #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd),
        .pre_exc_get(pre_exc_get), .pre_exc_code(pre_exc_code),
        .src_get(src_get), .src_code(src_code),
        .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
        .mem_size(mem_size), .mem_addr(mem_addr), .addr_ovf(addr_ovf),
        .out_valid(s_valid), .out_exc_get(s_get), .out_exc_code(s_code),
        .out_pc(s_pc), .out_bd(s_bd), .out_badvaddr(s_badv),
        .exc_req(s_req), .exc_ack(exc_ack), .hold_req(s_hold), .exc_count(s_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; in_valid = 0; in_pc = 0; in_bd = 0;
        pre_exc_get = 0; pre_exc_code = 0; src_get = 0; src_code = 0;
        mem_is_load = 0; mem_is_store = 0; mem_size = 0; mem_addr = 0;
        addr_ovf = 0; exc_ack = 0;
    endtask

    task automatic test_reset();
        reset = 1; clear_inputs(); step(); step();
        checks++;
        if ({out_valid, out_exc_get, out_exc_code, out_pc, out_bd, out_badvaddr, exc_req, hold_req, exc_count} !== '0) begin
            errors++; $display("FAIL reset_outputs: got valid=%b get=%b req=%b count=%0d, expected all 0", out_valid, out_exc_get, exc_req, exc_count);
        end
        reset = 0;
        in_valid = 1; in_pc = 32'h200; src_get = 2'b01; src_code = {5'd8, 5'd12};
        step(); clear_inputs(); step();
        checks++;
        if (exc_req !== 1'b1) begin errors++; $display("FAIL reset_setup_req: got %b expected 1", exc_req); end
        reset = 1; step(); reset = 0;
        checks++;
        if ({out_valid, out_exc_get, out_exc_code, out_pc, out_badvaddr, exc_req, hold_req, exc_count} !== '0) begin
            errors++; $display("FAIL reset_mid_report: got valid=%b get=%b req=%b hold=%b, expected all 0", out_valid, out_exc_get, exc_req, hold_req);
        end
        step();
        checks++;
        if ({exc_req, out_valid} !== 2'b00) begin errors++; $display("FAIL reset_no_ack: got req=%b valid=%b expected 0 0", exc_req, out_valid); end
    endtask

    task automatic test_alignment();
        in_valid = 1; in_pc = 32'h100; mem_is_load = 1; mem_size = 2'd2; mem_addr = 32'h1002;
        step();
        checks++;
        if ({out_exc_get, out_exc_code, out_badvaddr, exc_req} !== {1'b1, 5'd4, 32'h1002, 1'b0}) begin
            errors++; $display("FAIL align_load: got get=%b code=%0d badv=%h req=%b expected 1 4 00001002 0", out_exc_get, out_exc_code, out_badvaddr, exc_req);
        end
        step();
        checks++;
        if ({exc_req, hold_req, out_exc_code} !== {1'b1, 1'b1, 5'd4}) begin
            errors++; $display("FAIL align_report: got req=%b hold=%b code=%0d expected 1 1 4", exc_req, hold_req, out_exc_code);
        end
        clear_inputs(); exc_ack = 1; step(); exc_ack = 0;
        checks++;
        if ({exc_req, hold_req, out_valid, out_exc_get, exc_count} !== {4'b0000, 8'd1}) begin
            errors++; $display("FAIL align_ack: got req=%b valid=%b count=%0d expected 0 0 1", exc_req, out_valid, exc_count);
        end
    endtask

    task automatic report_case(input string name, input logic [4:0] code, input logic [31:0] badv, input logic [7:0] cnt);
        step();
        checks++;
        if ({out_valid, out_exc_get, out_exc_code, out_badvaddr} !== {1'b1, 1'b1, code, badv}) begin
            errors++; $display("FAIL %s: got code=%0d badv=%h expected code=%0d badv=%h", name, out_exc_code, out_badvaddr, code, badv);
        end
        step();
        clear_inputs(); exc_ack = 1; step(); exc_ack = 0;
        checks++;
        if ({exc_req, out_valid, exc_count} !== {2'b00, cnt}) begin
            errors++; $display("FAIL %s_ack: got req=%b valid=%b count=%0d expected 0 0 %0d", name, exc_req, out_valid, exc_count, cnt);
        end
    endtask

    task automatic set_priority_inputs();
        in_valid = 1; in_pc = 32'h300; mem_is_store = 1; mem_size = 2'd1; mem_addr = 32'h3;
        src_code = {5'd8, 5'd12};
    endtask

    task automatic test_priority();
        set_priority_inputs(); pre_exc_get = 1; pre_exc_code = 5'd10; src_get = 2'b11;
        report_case("prio_pre", 5'd10, 32'h0, 8'd2);
        set_priority_inputs(); src_get = 2'b11;
        report_case("prio_src0", 5'd12, 32'h0, 8'd3);
        set_priority_inputs();
        report_case("prio_ades", 5'd5, 32'h3, 8'd4);
    endtask

    task automatic test_stall_flush();
        clear_inputs(); in_valid = 1; in_pc = 32'h3000; in_bd = 1;
        step();
        checks++;
        if ({out_valid, out_exc_get, out_pc, out_bd} !== {2'b10, 32'h3000, 1'b1}) begin
            errors++; $display("FAIL sf_load: got valid=%b get=%b pc=%h expected 1 0 00003000", out_valid, out_exc_get, out_pc);
        end
        stall = 1; in_pc = 32'h4000;
        step();
        checks++;
        if (out_pc !== 32'h3000) begin errors++; $display("FAIL sf_stall: got pc=%h expected 00003000", out_pc); end
        flush = 1;
        step();
        checks++;
        if ({out_valid, out_pc, out_bd} !== '0) begin errors++; $display("FAIL sf_flush: got valid=%b pc=%h expected 0 0", out_valid, out_pc); end
        clear_inputs();
    endtask

    task automatic test_handshake();
        in_valid = 1; in_pc = 32'h5000; src_get = 2'b10; src_code = {5'd8, 5'd12};
        step(); step();
        for (int i = 0; i < 5; i++) begin
            flush = i[0]; in_pc = 32'h6000 + i; src_get = 2'b01;
            step();
            checks++;
            if ({exc_req, out_valid, out_pc, out_exc_code} !== {2'b11, 32'h5000, 5'd8}) begin
                errors++; $display("FAIL hs_hold%0d: got req=%b pc=%h code=%0d expected 1 00005000 8", i, exc_req, out_pc, out_exc_code);
            end
        end
        clear_inputs(); exc_ack = 1; step(); exc_ack = 0;
        checks++;
        if ({exc_req, exc_count} !== {1'b0, 8'd5}) begin
            errors++; $display("FAIL hs_ack: got req=%b count=%0d expected 0 5", exc_req, exc_count);
        end
    endtask

    task automatic test_saturation();
        in_valid = 0; src_get = 2'b11; src_code = {5'd8, 5'd12};
        step();
        checks++;
        if ({out_valid, out_exc_get, out_exc_code} !== '0) begin
            errors++; $display("FAIL sat_invalid: got valid=%b get=%b code=%0d expected 0 0 0", out_valid, out_exc_get, out_exc_code);
        end
        step();
        checks++;
        if (exc_req !== 1'b0) begin errors++; $display("FAIL sat_invalid_req: got %b expected 0", exc_req); end
        checks++;
        if (s_count !== 2'd3) begin errors++; $display("FAIL sat_count5: got %0d expected 3", s_count); end
        clear_inputs(); in_valid = 1; mem_is_load = 1; mem_size = 2'd0; mem_addr = 32'h10; addr_ovf = 1;
        report_case("ovf_load", 5'd4, 32'h10, 8'd6);
        checks++;
        if (s_count !== 2'd3) begin errors++; $display("FAIL sat_count6: got %0d expected 3", s_count); end
        clear_inputs(); in_valid = 1; mem_is_store = 1; mem_size = 2'd3; mem_addr = 32'h22;
        report_case("rsvd_size_store", 5'd5, 32'h22, 8'd7);
    endtask

    initial begin
        test_reset();
        test_alignment();
        test_priority();
        test_stall_flush();
        test_handshake();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_pipe_collector.md
Name: exc_pipe_collector

Overview:
- Parametrised successor of the per-stage exception checker.
- Merges an incoming exception with NUM_SRC local exception sources and a built-in address-error check (alignment plus address overflow), in a fixed priority.
- Registers the result as a pipeline stage with stall and flush.
- Reports the first excepting instruction to CP0 through a req/ack handshake, holding the pipeline until CP0 accepts it.
- Sits between the E and M pipeline registers; one instance per stage that can raise exceptions.

Parameters:
- NUM_SRC, 2, number of local exception sources; index 0 has the highest priority.
- CODE_W, 5, ExcCode width.
- ADDR_W, 32, data-address and PC width.
- CNT_W, 8, width of the saturating exception counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold this stage's register.
- flush  in  1  load a bubble into this stage's register.
- in_valid  in  1  incoming slot holds a real instruction.
- in_pc  in  ADDR_W  PC of the incoming instruction.
- in_bd  in  1  incoming instruction is in a branch delay slot.
- pre_exc_get  in  1  exception raised by an earlier stage.
- pre_exc_code  in  CODE_W  code for pre_exc_get.
- src_get  in  NUM_SRC  local exception requests.
- src_code  in  NUM_SRC*CODE_W  codes; slice i is source i.
- mem_is_load  in  1  instruction is a load.
- mem_is_store  in  1  instruction is a store.
- mem_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- mem_addr  in  ADDR_W  computed data address.
- addr_ovf  in  1  address adder overflowed.
- out_valid  out  1  registered slot is valid.
- out_exc_get  out  1  registered exception flag.
- out_exc_code  out  CODE_W  registered exception code.
- out_pc  out  ADDR_W  registered PC.
- out_bd  out  1  registered delay-slot flag.
- out_badvaddr  out  ADDR_W  faulting address; 0 when the exception is not an address error.
- exc_req  out  1  exception report to CP0.
- exc_ack  in  1  CP0 accepts the report.
- hold_req  out  1  upstream stall request.
- exc_count  out  CNT_W  saturating count of acknowledged reports.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset: every output is 0 and the FSM is IDLE. A reset asserted mid-handshake abandons the report with no ack required.
- Address error, combinational: mis = (size 1 and addr[0]) or (size 2 and addr[1:0] != 0). Size 3 is treated as word.
  - ae = (mem_is_load or mem_is_store) and (mis or addr_ovf).
  - Code is ExcAdEL (4) for loads and ExcAdES (5) for stores. If load and store are both set, the store wins.
- Merge priority, combinational:
  1. pre_exc_get, with pre_exc_code passed through.
  2. src_get[0] through src_get[NUM_SRC-1], lowest index first.
  3. ae.
  - If none apply, there is no exception and the code is 0.
  - badvaddr = mem_addr only when ae is the selected cause, otherwise 0.
  - When in_valid = 0, exc_get and code are forced to 0.
- Register update, per cycle, in priority order:
  1. reset.
  2. FSM in REPORT: hold.
  3. flush: bubble, with all out_* set to 0.
  4. stall: hold.
  5. Otherwise: load the merged values.
  - flush wins over stall.
- FSM:
  - IDLE to REPORT when out_valid and out_exc_get are both 1 after a register update.
  - In REPORT, exc_req = 1 and hold_req = 1; exc_req is a Moore output.
  - REPORT to IDLE on the edge where exc_ack = 1. On that same edge the register is loaded with a bubble, because the instruction is consumed by the exception, and exc_count increments, saturating at all-ones.
  - exc_ack is ignored in IDLE.
  - Report latency: 1 cycle from register load to exc_req.
  - An exception arriving while in REPORT is not seen until the stage reopens.
- hold_req = 1 in REPORT, 0 otherwise. stall and flush inputs are ignored during REPORT.

Decomposition:
- define.v holds:
  - ExcCode constants: ExcAdEL = 4, ExcAdES = 5, ExcOV = 12.
  - Access-size encodings.
  - FSM state encodings: IDLE = 0, REPORT = 1.
- Sub-module exc_prio_enc holds the combinational priority merge and the address-error logic.
- The top module holds the pipeline register, the FSM and the counter.

Test Plan:
1. Reset: assert reset with exc_req high in REPORT -> next cycle all outputs are 0, the FSM is IDLE, and no ack is needed.
2. Alignment: lw with addr 0x1002, size 2, in_valid -> after one edge out_exc_code = 4 and out_badvaddr = 0x00001002. After the next edge exc_req = 1 and hold_req = 1. Apply ack -> bubble loaded and exc_count = 1.
3. Priority: pre_exc_get with code 10, src_get = 2'b11 with codes 12/8, sh with addr 0x3 -> out_exc_code = 10 and out_badvaddr = 0. Remove pre_exc_get -> code 12. Clear src_get -> code 5 and badvaddr = 3.
4. Stall vs flush: load a valid, non-excepting slot with pc 0x3000. Then:
   - stall = 1 -> out_pc stays 0x3000.
   - stall = 1 and flush = 1 together -> bubble, out_valid = 0.
5. Handshake hold: in REPORT, keep exc_ack = 0 for 5 cycles while toggling flush -> out_* unchanged and exc_req stays 1. Ack on cycle 6 -> exc_req = 0 on the next cycle.
6. Saturation: with CNT_W = 2, complete 5 acknowledged reports -> exc_count = 3. Also drive in_valid = 0 with src_get set -> no exception raised.
